// File: rtl/iterative_divider.sv
`default_nettype none
// ============================================================================
// Module   : iterative_divider
// Purpose  : Radix-2 restoring divider, signed/unsigned, one quotient bit per
//            cycle, with request/result valid-ready handshakes and flush.
// Revision : 1.0 - initial release
// ============================================================================
module iterative_divider #(
  parameter int WIDTH = 32
) (
  input  logic             div_clk,
  input  logic             resetn,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] SIGN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  // Dividend magnitude shifts out of the top while quotient bits shift in
  // at the bottom, so one register serves both.
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] x_orig;
  logic             q_neg;
  logic             r_neg;
  logic             zero;

  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  assign div_ready = (state == IDLE);

  // Operand magnitudes: negate only signed operands whose MSB is set.
  assign x_mag = (div_signed && x[WIDTH-1]) ? -x : x;
  assign y_mag = (div_signed && y[WIDTH-1]) ? -y : y;

  // Shift next dividend bit into the partial remainder and trial-subtract;
  // the extra top bit is the borrow that decides restore vs keep.
  assign trial = {rem, dq[WIDTH-1]} - {1'b0, dvsr};

  // Sign correction, modulo 2^WIDTH (so -2^(W-1)/-1 wraps naturally).
  assign q_fin = q_neg ? -dq  : dq;
  assign r_fin = r_neg ? -rem : rem;

  // Control FSM and iteration datapath.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      count  <= '0;
      dq     <= '0;
      dvsr   <= '0;
      rem    <= '0;
      x_orig <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      zero   <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            dq     <= x_mag;
            dvsr   <= y_mag;
            x_orig <= x;
            q_neg  <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            r_neg  <= div_signed & x[WIDTH-1];
            zero   <= (y == '0);
            rem    <= '0;
            count  <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            dq  <= {dq[WIDTH-2:0], 1'b1};
          end else begin
            rem <= {rem[WIDTH-2:0], dq[WIDTH-1]};
            dq  <= {dq[WIDTH-2:0], 1'b0};
          end
          count <= count + 1'b1;
          if (count == LAST_STEP) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result registers: loaded once in SIGN, held through DONE; flush only
  // drops the valid flag so s/r keep their last values.
  always_ff @(posedge div_clk or negedge resetn) begin
    if (!resetn) begin
      out_valid   <= 1'b0;
      s           <= '0;
      r           <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (state == SIGN) begin
      s           <= zero ? '1 : q_fin;
      r           <= zero ? x_orig : r_fin;
      div_by_zero <= zero;
      out_valid   <= 1'b1;
    end else if ((state == DONE) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
